// File: rtl/scl_gen_stall_param.sv
// Parametrised SCL generator with push-pull/open-drain phase timing and an
// integrated clock-stretch engine that extends the low phase on request.
module scl_gen_stall_param #(
    parameter int CNT_W   = 8,
    parameter int PP_LOW  = 2,
    parameter int PP_HIGH = 2,
    parameter int OD_LOW  = 10,
    parameter int OD_HIGH = 2,
    parameter int STALL_W = 5
) (
    input  logic               i_scl_gen_clk,
    input  logic               i_scl_gen_rst,
    input  logic               i_scl_gen_en,
    input  logic               i_scl_gen_pp_od,
    input  logic               i_scl_gen_stall,
    input  logic [STALL_W-1:0] i_stall_cycles,
    output logic               o_scl,
    output logic               o_scl_pos_edge,
    output logic               o_scl_neg_edge,
    output logic               o_stall_done,
    output logic               o_scl_stalled,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        STALL = 2'd2,
        HIGH  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PP_LOW_C  = CNT_W'(PP_LOW);
    localparam logic [CNT_W-1:0] PP_HIGH_C = CNT_W'(PP_HIGH);
    localparam logic [CNT_W-1:0] OD_LOW_C  = CNT_W'(OD_LOW);
    localparam logic [CNT_W-1:0] OD_HIGH_C = CNT_W'(OD_HIGH);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               mode_pp;
    logic [CNT_W-1:0]   low_len;
    logic [CNT_W-1:0]   high_len;
    logic               low_end;
    logic               stall_end;
    logic               high_end;
    logic               period_start;

    logic scl_next;
    logic pos_next;
    logic neg_next;
    logic done_next;
    logic stalled_next;
    logic busy_next;

    // Mode is latched once per period, so the lengths stay fixed until the next low phase.
    assign low_len      = mode_pp ? PP_LOW_C  : OD_LOW_C;
    assign high_len     = mode_pp ? PP_HIGH_C : OD_HIGH_C;
    assign low_end      = (state == LOW)   && (cnt == low_len - CNT_W'(1));
    assign stall_end    = (state == STALL) && (stall_cnt == STALL_W'(1));
    assign high_end     = (state == HIGH)  && (cnt == high_len - CNT_W'(1));
    assign period_start = (next_state == LOW) && (state != LOW);

    always_ff @(posedge i_scl_gen_clk or posedge i_scl_gen_rst) begin
        if (i_scl_gen_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
            mode_pp   <= 1'b1;
        end else begin
            state <= next_state;
            if ((next_state == state) && ((state == LOW) || (state == HIGH)))
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
            // Stall length is captured only at the low-phase end; later input changes are ignored.
            if ((state == LOW) && (next_state == STALL))
                stall_cnt <= i_stall_cycles;
            else if (state == STALL)
                stall_cnt <= stall_cnt - STALL_W'(1);
            else
                stall_cnt <= '0;
            if (period_start)
                mode_pp <= i_scl_gen_pp_od;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_scl_gen_en)
                    next_state = LOW;
            end
            LOW: begin
                if (low_end) begin
                    if (i_scl_gen_stall && (i_stall_cycles != '0))
                        next_state = STALL;
                    else
                        next_state = HIGH;
                end
            end
            STALL: begin
                if (stall_end)
                    next_state = HIGH;
            end
            HIGH: begin
                if (high_end)
                    next_state = i_scl_gen_en ? LOW : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs derive from the next state so pulses line up with the registered SCL change.
    always_comb begin
        scl_next     = !((next_state == LOW) || (next_state == STALL));
        pos_next     = ((state == LOW) || (state == STALL)) && (next_state == HIGH);
        neg_next     = (next_state == LOW) && (state != LOW);
        done_next    = ((state == STALL) && (next_state == HIGH)) ||
                       ((state == LOW) && (next_state == HIGH) &&
                        i_scl_gen_stall && (i_stall_cycles == '0));
        stalled_next = (next_state == STALL);
        busy_next    = (next_state != IDLE);
    end

    always_ff @(posedge i_scl_gen_clk or posedge i_scl_gen_rst) begin
        if (i_scl_gen_rst) begin
            o_scl          <= 1'b1;
            o_scl_pos_edge <= 1'b0;
            o_scl_neg_edge <= 1'b0;
            o_stall_done   <= 1'b0;
            o_scl_stalled  <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_scl          <= scl_next;
            o_scl_pos_edge <= pos_next;
            o_scl_neg_edge <= neg_next;
            o_stall_done   <= done_next;
            o_scl_stalled  <= stalled_next;
            o_busy         <= busy_next;
        end
    end

endmodule

// File: doc/scl_gen_stall_param.md
Name: scl_gen_stall_param

Overview:
Parametrised SCL generator with an integrated clock-stretch (stall) engine for the I3C SDR controller. It is the successor to the fixed scl_generation/scl_staller pair. It supports independently parametrised push-pull and open-drain low/high phase lengths, mode switching at period boundaries, and a stall-length input per request. It emits a registered SCL with aligned edge pulses that the SDR controller, bit counters and data shifters consume.

Parameters:
CNT_W, 8, width of phase counters; every phase-length parameter must fit in CNT_W bits.
PP_LOW, 2, push-pull low phase in clock cycles (>=1).
PP_HIGH, 2, push-pull high phase in clock cycles (>=1).
OD_LOW, 10, open-drain low phase in clock cycles (>=1).
OD_HIGH, 2, open-drain high phase in clock cycles (>=1).
STALL_W, 5, width of the stall-cycle request.

Ports:
i_scl_gen_clk  in  1  system clock; all logic on its rising edge.
i_scl_gen_rst  in  1  asynchronous, active-high reset.
i_scl_gen_en  in  1  1 = generate SCL; 0 = park SCL high (bus idle).
i_scl_gen_pp_od  in  1  1 = push-pull timing, 0 = open-drain timing.
i_scl_gen_stall  in  1  stall request; level, held until o_stall_done.
i_stall_cycles  in  STALL_W  extra low cycles per stall.
o_scl  out  1  registered SCL.
o_scl_pos_edge  out  1  1-cycle pulse, asserted in the cycle o_scl first reads 1.
o_scl_neg_edge  out  1  1-cycle pulse, asserted in the cycle o_scl first reads 0.
o_stall_done  out  1  1-cycle pulse ending a stall.
o_scl_stalled  out  1  high while the stall extension holds SCL low.
o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_scl=1, all pulses 0, o_scl_stalled=0, o_busy=0, counters 0, latched mode=PP.
- All outputs are registered. Edge pulses are registered together with o_scl from the next-state value, so each pulse coincides with the cycle o_scl changes.
- Phase lengths are latched on every IDLE->LOW or HIGH->LOW transition: {PP_LOW,PP_HIGH} if i_scl_gen_pp_od=1, else {OD_LOW,OD_HIGH}. A mode change mid-period takes effect on the next period only.
- FSM states: IDLE, LOW, STALL, HIGH.
- IDLE: o_scl=1. If en=1 at an edge, go to LOW. o_scl=0 and o_scl_neg_edge=1 after that edge.
- LOW: lasts exactly low_len cycles. On the last cycle:
  - stall=1 and i_stall_cycles=N>0: go to STALL and load the stall counter with N (captured here; later changes are ignored).
  - stall=1 and N=0: go to HIGH, with o_stall_done pulsed together with o_scl_pos_edge.
  - stall=0: go to HIGH with o_scl_pos_edge.
- STALL: o_scl=0, o_scl_stalled=1, lasts exactly N cycles. Total low time = low_len+N. On exit, go to HIGH; o_scl_pos_edge and o_stall_done pulse in the same cycle and o_scl_stalled drops.
- HIGH: lasts exactly high_len cycles. At its end, en=1 -> LOW with neg edge; en=0 -> IDLE with SCL held 1 and no edge pulse.
- Stall handshake: the requester deasserts i_scl_gen_stall upon o_stall_done. If the request is still high at the end of the next low phase, a new stall is taken.
- A stall request is only sampled at the end of a LOW phase. A request raised during HIGH/IDLE waits for the next low-phase end.
- Deassertion of en mid-LOW/STALL never truncates a phase: the current period completes (low, stall, high), then the FSM goes to IDLE.
- Nominal period in cycles: PP = PP_LOW+PP_HIGH (4), OD = OD_LOW+OD_HIGH (12).
- Async reset mid-operation (including STALL): o_scl=1 immediately. No edge or done pulse is generated, and the pending stall is discarded.
- Counters saturate at no boundary. Lengths are compared as unsigned CNT_W/STALL_W values, with no wrap beyond their range.

Test Plan:
1. Hold reset 3 cycles, en=0 -> o_scl=1, pulses=0, o_busy=0; after release SCL stays high for 10 cycles.
2. en=1, pp_od=1 -> o_scl falls after the first sampling edge, then repeats 2 low/2 high. A neg pulse occurs every 4 cycles and a pos pulse 2 cycles after each neg pulse.
3. pp_od switched 1->0 mid-low -> the current period stays 2/2. The next period is 10 low/2 high and remains 12-cycle periods afterwards.
4. PP mode, stall=1 with N=18, deasserted on o_stall_done -> that low lasts 20 cycles. o_scl_stalled is high for exactly 18 cycles, o_stall_done coincides with o_scl_pos_edge, and the following periods return to 4 cycles.
5. Stall with N=0 -> low lasts 2 cycles, o_stall_done pulses with pos edge, o_scl_stalled never asserts.
6. en dropped 3 cycles into an 18-cycle stall -> the stall and high phase complete, then IDLE with o_scl=1 and no further neg edge. A separate run asserts reset mid-stall -> o_scl=1 without a clock edge, no done pulse.
